// File: rtl/sram_like_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_like_arbiter_pkg
//  Description : Shared owner encodings, parameter defaults, grant type and
//                a width helper for the SRAM-like two-into-one arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package sram_like_arbiter_pkg;

   // Owner bit stored per accepted request
   localparam logic OWNER_INST = 1'b0;
   localparam logic OWNER_DATA = 1'b1;

   // Parameter defaults
   localparam int DEFAULT_OUTSTANDING  = 2;
   localparam int DEFAULT_STARVE_LIMIT = 3;

   // Which requester is presented downstream this cycle
   typedef enum logic [1:0] {
      GRANT_NONE = 2'd0,
      GRANT_INST = 2'd1,
      GRANT_DATA = 2'd2
   } grant_e;

   // Bits needed to hold values 0..max_value, never less than one bit
   function automatic int width_of(input int max_value);
      return (max_value < 2) ? 1 : $clog2(max_value + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sram_like_arbiter_owner_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : owner_fifo
//  Description : In-order 1-bit FIFO remembering which requester owns each
//                accepted-but-unanswered memory request.
//  Revision    : 1.0  initial release
// ============================================================================
module owner_fifo
   import sram_like_arbiter_pkg::*;
#(
   parameter int DEPTH = DEFAULT_OUTSTANDING
)
(
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  logic push_owner,
   input  logic pop,
   output logic full,
   output logic empty,
   output logic head
);

   localparam int PTR_W = width_of(DEPTH - 1);
   localparam int CNT_W = width_of(DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

   logic [DEPTH-1:0] r_slots;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   // Wrap at DEPTH explicitly so non-power-of-two pointer widths stay safe
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
   endfunction

   assign full   = (r_count == DEPTH_CNT);
   assign empty  = (r_count == '0);
   assign head   = r_slots[r_rd_ptr];
   assign w_push = push && !full;
   assign w_pop  = pop && !empty;

   // Owner storage, pointers and occupancy
   always_ff @(posedge clk) begin
      if (reset) begin
         r_slots  <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_slots[r_wr_ptr] <= push_owner;
            r_wr_ptr          <= next_ptr(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= next_ptr(r_rd_ptr);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/sram_like_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_like_arbiter
//  Description : Shares one SRAM-like memory port between instruction fetch
//                and data access; data has priority with a starvation guard,
//                responses are routed back in order via an owner FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
module sram_like_arbiter
   import sram_like_arbiter_pkg::*;
#(
   parameter int OUTSTANDING  = DEFAULT_OUTSTANDING,
   parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
)
(
   input  logic        clk,
   input  logic        reset,

   input  logic        inst_sram_req,
   input  logic [3:0]  inst_sram_wen,
   input  logic [31:0] inst_sram_addr,
   input  logic [31:0] inst_sram_wdata,
   output logic        inst_sram_addr_ok,
   output logic        inst_sram_data_ok,
   output logic [31:0] inst_sram_rdata,

   input  logic        data_sram_req,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic        data_sram_addr_ok,
   output logic        data_sram_data_ok,
   output logic [31:0] data_sram_rdata,

   output logic        mem_req,
   output logic [3:0]  mem_wen,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata
);

   localparam int STARVE_W = width_of(STARVE_LIMIT);
   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

   grant_e              w_grant;
   logic                w_accept;
   logic                w_fifo_full;
   logic                w_fifo_empty;
   logic                w_fifo_head;
   logic                w_resp_valid;
   logic [STARVE_W-1:0] r_starve_cnt;

   // Data wins by default; inst wins when alone or once data has starved it
   always_comb begin
      w_grant = GRANT_NONE;
      if (inst_sram_req && (!data_sram_req || r_starve_cnt == STARVE_MAX)) begin
         w_grant = GRANT_INST;
      end else if (data_sram_req) begin
         w_grant = GRANT_DATA;
      end
   end

   // Full uses the registered count, so a same-cycle pop cannot unblock
   assign mem_req   = (inst_sram_req || data_sram_req) && !w_fifo_full && !reset;
   assign mem_wen   = (w_grant == GRANT_INST) ? inst_sram_wen   : data_sram_wen;
   assign mem_addr  = (w_grant == GRANT_INST) ? inst_sram_addr  : data_sram_addr;
   assign mem_wdata = (w_grant == GRANT_INST) ? inst_sram_wdata : data_sram_wdata;

   assign w_accept          = mem_req && mem_addr_ok;
   assign inst_sram_addr_ok = w_accept && (w_grant == GRANT_INST);
   assign data_sram_addr_ok = w_accept && (w_grant == GRANT_DATA);

   // A response with nothing outstanding is dropped silently
   assign w_resp_valid      = mem_data_ok && !w_fifo_empty;
   assign inst_sram_data_ok = w_resp_valid && (w_fifo_head == OWNER_INST);
   assign data_sram_data_ok = w_resp_valid && (w_fifo_head == OWNER_DATA);
   assign inst_sram_rdata   = mem_rdata;
   assign data_sram_rdata   = mem_rdata;

   owner_fifo #(
      .DEPTH      (OUTSTANDING)
   ) u_owner_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (w_accept),
      .push_owner ((w_grant == GRANT_DATA) ? OWNER_DATA : OWNER_INST),
      .pop        (mem_data_ok),
      .full       (w_fifo_full),
      .empty      (w_fifo_empty),
      .head       (w_fifo_head)
   );

   // Count data grants that overtook a waiting inst request
   always_ff @(posedge clk) begin
      if (reset) begin
         r_starve_cnt <= '0;
      end else if (!inst_sram_req || inst_sram_addr_ok) begin
         r_starve_cnt <= '0;
      end else if (data_sram_addr_ok && r_starve_cnt != STARVE_MAX) begin
         r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sram_like_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_like_arbiter
//  Description : Directed and randomized bench for sram_like_arbiter against
//                a queue-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sram_like_arbiter;

   localparam int OUT = 2;
   localparam int LIM = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_sram_req, data_sram_req;
   logic [3:0]  inst_sram_wen, data_sram_wen;
   logic [31:0] inst_sram_addr, inst_sram_wdata, data_sram_addr, data_sram_wdata;
   logic        inst_sram_addr_ok, inst_sram_data_ok, data_sram_addr_ok, data_sram_data_ok;
   logic [31:0] inst_sram_rdata, data_sram_rdata;
   logic        mem_req, mem_addr_ok, mem_data_ok;
   logic [3:0]  mem_wen;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int checks   = 0;
   int failures = 0;

   // Reference model: queue of owners (1 = data) and a starvation tally
   bit owner_q[$];
   int starve_m = 0;

   always #5 clk = ~clk;

   sram_like_arbiter #(
      .OUTSTANDING       (OUT),
      .STARVE_LIMIT      (LIM)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .inst_sram_req     (inst_sram_req),
      .inst_sram_wen     (inst_sram_wen),
      .inst_sram_addr    (inst_sram_addr),
      .inst_sram_wdata   (inst_sram_wdata),
      .inst_sram_addr_ok (inst_sram_addr_ok),
      .inst_sram_data_ok (inst_sram_data_ok),
      .inst_sram_rdata   (inst_sram_rdata),
      .data_sram_req     (data_sram_req),
      .data_sram_wen     (data_sram_wen),
      .data_sram_addr    (data_sram_addr),
      .data_sram_wdata   (data_sram_wdata),
      .data_sram_addr_ok (data_sram_addr_ok),
      .data_sram_data_ok (data_sram_data_ok),
      .data_sram_rdata   (data_sram_rdata),
      .mem_req           (mem_req),
      .mem_wen           (mem_wen),
      .mem_addr          (mem_addr),
      .mem_wdata         (mem_wdata),
      .mem_addr_ok       (mem_addr_ok),
      .mem_data_ok       (mem_data_ok),
      .mem_rdata         (mem_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: drive at negedge, compare against the model, advance the model
   task automatic step(input bit rst, input bit ir, input bit dr, input bit mao, input bit mdo,
                       input logic [31:0] ia, input logic [31:0] da, input logic [31:0] rd);
      bit full_m, req_m, gi, gd, acc, pop_m, head_m;
      @(negedge clk);
      reset           = rst;
      inst_sram_req   = ir;
      inst_sram_addr  = ia;
      inst_sram_wen   = 4'($urandom_range(0, 15));
      inst_sram_wdata = $urandom();
      data_sram_req   = dr;
      data_sram_addr  = da;
      data_sram_wen   = 4'($urandom_range(0, 15));
      data_sram_wdata = $urandom();
      mem_addr_ok     = mao;
      mem_data_ok     = mdo;
      mem_rdata       = rd;
      #1;
      full_m = (owner_q.size() == OUT);
      req_m  = (ir || dr) && !full_m && !rst;
      gi     = ir && (!dr || starve_m == LIM);
      gd     = !gi && dr;
      acc    = req_m && mao;
      pop_m  = mdo && (owner_q.size() != 0);
      head_m = (owner_q.size() != 0) ? owner_q[0] : 1'b0;
      chk("mem_req",    {31'd0, mem_req},           {31'd0, req_m});
      chk("inst_addr_ok", {31'd0, inst_sram_addr_ok}, {31'd0, acc && gi});
      chk("data_addr_ok", {31'd0, data_sram_addr_ok}, {31'd0, acc && gd});
      chk("mem_addr",   mem_addr,  gi ? ia : da);
      chk("mem_wen",    {28'd0, mem_wen},   {28'd0, gi ? inst_sram_wen : data_sram_wen});
      chk("mem_wdata",  mem_wdata, gi ? inst_sram_wdata : data_sram_wdata);
      chk("inst_data_ok", {31'd0, inst_sram_data_ok}, {31'd0, pop_m && !head_m});
      chk("data_data_ok", {31'd0, data_sram_data_ok}, {31'd0, pop_m && head_m});
      chk("inst_rdata", inst_sram_rdata, rd);
      chk("data_rdata", data_sram_rdata, rd);
      if (rst) begin
         owner_q.delete();
         starve_m = 0;
      end else begin
         if (pop_m) void'(owner_q.pop_front());
         if (acc) owner_q.push_back(gd);
         if (!ir || (acc && gi)) starve_m = 0;
         else if (acc && gd && starve_m < LIM) starve_m++;
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, $urandom(), $urandom(), $urandom());
   endtask

   initial begin
      string       pattern;
      logic [7:0]  seen;
      reset = 1'b1;
      inst_sram_req = 0; data_sram_req = 0; inst_sram_wen = 0; data_sram_wen = 0;
      inst_sram_addr = 0; data_sram_addr = 0; inst_sram_wdata = 0; data_sram_wdata = 0;
      mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;

      // Reset held with both requesters active
      for (int k = 0; k < 3; k++) begin
         step(1, 1, 1, 1, 0, 32'h1000_0000, 32'h2000_0000, $urandom());
         chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
         chk("rst_addr_ok", {30'd0, inst_sram_addr_ok, data_sram_addr_ok}, 32'd0);
      end
      idle(1);

      // Instruction fetch alone
      step(0, 1, 0, 1, 0, 32'h1FC0_0000, 32'h0, 32'h0);
      chk("inst_alone_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd1);
      chk("inst_alone_addr", mem_addr, 32'h1FC0_0000);
      idle(1);
      step(0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h3C1D_BFC0);
      chk("inst_alone_data_ok", {30'd0, inst_sram_data_ok, data_sram_data_ok}, 32'd2);
      chk("inst_alone_rdata", inst_sram_rdata, 32'h3C1D_BFC0);

      // Contention: data first, then inst; responses in that order
      step(0, 1, 1, 1, 0, 32'h1FC0_0004, 32'h8000_0100, 32'h0);
      chk("cont_grant_data", mem_addr, 32'h8000_0100);
      chk("cont_data_addr_ok", {31'd0, data_sram_addr_ok}, 32'd1);
      step(0, 1, 0, 1, 0, 32'h1FC0_0004, 32'h8000_0100, 32'h0);
      chk("cont_inst_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd1);
      step(0, 0, 0, 0, 1, 32'h0, 32'h0, 32'hAAAA_0001);
      chk("cont_resp1_data", {30'd0, inst_sram_data_ok, data_sram_data_ok}, 32'd1);
      step(0, 0, 0, 0, 1, 32'h0, 32'h0, 32'hAAAA_0002);
      chk("cont_resp2_inst", {30'd0, inst_sram_data_ok, data_sram_data_ok}, 32'd2);

      // Stray response while empty
      step(0, 0, 0, 0, 1, 32'h0, 32'h0, 32'hDEAD_BEEF);
      chk("stray_data_ok", {30'd0, inst_sram_data_ok, data_sram_data_ok}, 32'd0);

      // Starvation guard: both held, memory always ready
      step(1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
      pattern = "DDDIDDDI";
      for (int k = 0; k < 8; k++) begin
         step(0, 1, 1, 1, 1, 32'h1FC0_1000 + k, 32'h8000_2000 + k, $urandom());
         seen = inst_sram_addr_ok ? 8'h49 : (data_sram_addr_ok ? 8'h44 : 8'h2D);
         chk("starve_grant", {24'd0, seen}, {24'd0, pattern[k]});
      end

      // Full FIFO blocks even when a response pops the same cycle
      step(1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
      step(0, 1, 0, 1, 0, 32'h1FC0_2000, 32'h0, 32'h0);
      step(0, 0, 1, 1, 0, 32'h0, 32'h8000_3000, 32'h0);
      step(0, 1, 0, 1, 0, 32'h1FC0_2004, 32'h0, 32'h0);
      chk("full_blocks", {31'd0, mem_req}, 32'd0);
      step(0, 1, 0, 1, 1, 32'h1FC0_2004, 32'h0, 32'h5555_0000);
      chk("full_pop_still_blocks", {31'd0, mem_req}, 32'd0);
      chk("full_pop_inst_resp", {31'd0, inst_sram_data_ok}, 32'd1);
      step(0, 1, 0, 1, 0, 32'h1FC0_2004, 32'h0, 32'h0);
      chk("full_then_granted", {31'd0, inst_sram_addr_ok}, 32'd1);

      // Randomized traffic with occasional resets
      for (int k = 0; k < 600; k++) begin
         bit rst;
         rst = ($urandom_range(0, 59) == 0);
         step(rst, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 1)), rst ? 1'b0 : 1'($urandom_range(0, 1)),
              $urandom(), $urandom(), $urandom());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
